// File: rtl/trap_sequencer.sv
// trap_sequencer: sequences M-mode trap entry / MRET return and owns the CSR write port
module trap_sequencer #(
    parameter bit          VECTORED_EN = 1'b1,
    parameter logic [11:0] CSR_MSTATUS = 12'h300,
    parameter logic [11:0] CSR_MEPC    = 12'h341,
    parameter logic [11:0] CSR_MCAUSE  = 12'h342,
    parameter logic [1:0]  MRET_MPP    = 2'b11
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_exception_pending,
    input  logic [31:0] i_cause,
    input  logic [31:0] i_pc_exc,
    input  logic        i_mret,
    input  logic        i_sret,
    input  logic        i_uret,
    input  logic        i_csr_we_c,
    input  logic [11:0] i_csr_addr_c,
    input  logic [31:0] i_csr_wdata_c,
    input  logic [31:0] i_mtvec_q,
    input  logic [31:0] i_mepc_q,
    input  logic [31:0] i_mstatus_q,
    output logic        o_csr_we,
    output logic [11:0] o_csr_addr,
    output logic [31:0] o_csr_wdata,
    output logic        o_stall_commit,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc,
    output logic        o_flush
);
    typedef enum logic [2:0] {
        S_IDLE, S_T_EPC, S_T_CAUSE, S_T_STATUS, S_T_REDIR, S_R_STATUS, S_R_REDIR
    } state_t;

    state_t      r_state, w_next;
    logic        r_live;
    logic [31:0] r_epc, r_cause;
    logic        w_start;
    logic [31:0] w_vec_off, w_trap_status, w_ret_status;

    // Outputs stay quiet from reset assertion until the first clock after release
    assign w_start       = (r_state == S_IDLE) && r_live && (i_exception_pending || i_sret || i_uret);
    assign w_vec_off     = (VECTORED_EN && i_mtvec_q[1:0] == 2'b01 && r_cause[31]) ? {r_cause[29:0], 2'b00} : 32'd0;
    assign w_trap_status = {i_mstatus_q[31:13], 2'b11, i_mstatus_q[10:8], i_mstatus_q[3], i_mstatus_q[6:4], 1'b0, i_mstatus_q[2:0]};
    assign w_ret_status  = {i_mstatus_q[31:13], MRET_MPP, i_mstatus_q[10:8], 1'b1, i_mstatus_q[6:4], i_mstatus_q[7], i_mstatus_q[2:0]};

    // State register plus the output-enable that holds outputs at 0 through reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
        end
    end

    // Capture trapping PC and cause; unsupported xRET becomes illegal-instruction
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_epc   <= 32'd0;
            r_cause <= 32'd0;
        end else if (w_start) begin
            r_epc   <= i_pc_exc;
            r_cause <= i_exception_pending ? i_cause : 32'd2;
        end
    end

    // Next-state and CSR-port / redirect decode
    always_comb begin
        w_next           = r_state;
        o_csr_we         = 1'b0;
        o_csr_addr       = 12'd0;
        o_csr_wdata      = 32'd0;
        o_redirect_valid = 1'b0;
        o_redirect_pc    = 32'd0;
        o_flush          = 1'b0;
        o_stall_commit   = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: if (r_live) begin
                o_csr_we    = i_csr_we_c & ~i_exception_pending;
                o_csr_addr  = i_csr_addr_c;
                o_csr_wdata = i_csr_wdata_c;
                w_next      = w_start ? S_T_EPC : (i_mret ? S_R_STATUS : S_IDLE);
            end
            S_T_EPC: begin
                o_csr_we    = 1'b1;
                o_csr_addr  = CSR_MEPC;
                o_csr_wdata = {r_epc[31:2], 2'b00};
                w_next      = S_T_CAUSE;
            end
            S_T_CAUSE: begin
                o_csr_we    = 1'b1;
                o_csr_addr  = CSR_MCAUSE;
                o_csr_wdata = r_cause;
                w_next      = S_T_STATUS;
            end
            S_T_STATUS: begin
                o_csr_we    = 1'b1;
                o_csr_addr  = CSR_MSTATUS;
                o_csr_wdata = w_trap_status;
                w_next      = S_T_REDIR;
            end
            S_T_REDIR: begin
                o_redirect_valid = 1'b1;
                o_flush          = 1'b1;
                o_redirect_pc    = {i_mtvec_q[31:2], 2'b00} + w_vec_off;
                w_next           = S_IDLE;
            end
            S_R_STATUS: begin
                o_csr_we    = 1'b1;
                o_csr_addr  = CSR_MSTATUS;
                o_csr_wdata = w_ret_status;
                w_next      = S_R_REDIR;
            end
            S_R_REDIR: begin
                o_redirect_valid = 1'b1;
                o_flush          = 1'b1;
                o_redirect_pc    = {i_mepc_q[31:2], 2'b00};
                w_next           = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed vectors for trap entry, MRET return and reset abort
module tb_trap_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc, mret, sret, uret, we_c;
    logic [31:0] cause, pc_exc, wdata_c, mtvec, mepc, mstatus;
    logic [11:0] addr_c;
    logic        csr_we, stall, rv, flush;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, rpc;
    int          n_vec = 0;
    int          n_bad = 0;

    trap_sequencer dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_exception_pending(exc), .i_cause(cause),
        .i_pc_exc(pc_exc), .i_mret(mret), .i_sret(sret), .i_uret(uret),
        .i_csr_we_c(we_c), .i_csr_addr_c(addr_c), .i_csr_wdata_c(wdata_c),
        .i_mtvec_q(mtvec), .i_mepc_q(mepc), .i_mstatus_q(mstatus),
        .o_csr_we(csr_we), .o_csr_addr(csr_addr), .o_csr_wdata(csr_wdata),
        .o_stall_commit(stall), .o_redirect_valid(rv), .o_redirect_pc(rpc), .o_flush(flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        exc = 0; mret = 0; sret = 0; uret = 0; we_c = 0;
        cause = 0; pc_exc = 0; addr_c = 0; wdata_c = 0;
    endtask

    task automatic out(input string tag, input logic we, input logic [11:0] a, input logic [31:0] d,
                       input logic st, input logic r, input logic [31:0] p);
        #2;
        chk({tag, ".we"}, {31'd0, csr_we}, {31'd0, we});
        if (we) chk({tag, ".addr"}, {20'd0, csr_addr}, {20'd0, a});
        if (we) chk({tag, ".wdata"}, csr_wdata, d);
        chk({tag, ".stall"}, {31'd0, stall}, {31'd0, st});
        chk({tag, ".rv"}, {31'd0, rv}, {31'd0, r});
        chk({tag, ".flush"}, {31'd0, flush}, {31'd0, r});
        if (r) chk({tag, ".rpc"}, rpc, p);
    endtask

    initial begin
        clr();
        mtvec = 0; mepc = 0; mstatus = 0;
        rst_n = 0;
        we_c = 1; addr_c = 12'h305; wdata_c = 32'h1000;
        #3;
        chk("rst.we", {31'd0, csr_we}, 32'd0);
        chk("rst.addr", {20'd0, csr_addr}, 32'd0);
        chk("rst.wdata", csr_wdata, 32'd0);
        chk("rst.stall", {31'd0, stall}, 32'd0);
        chk("rst.rv", {31'd0, rv}, 32'd0);
        chk("rst.rpc", rpc, 32'd0);
        @(negedge clk) rst_n = 1;
        tick();
        out("t1", 1, 12'h305, 32'h1000, 0, 0, 0);
        tick(); clr();
        exc = 1; cause = 2; pc_exc = 32'h80000104; mtvec = 32'h80000000; mstatus = 32'h8;
        out("t2.idle", 0, 0, 0, 0, 0, 0);
        tick(); clr(); we_c = 1; addr_c = 12'h305; wdata_c = 32'hdead;
        out("t2.epc", 1, 12'h341, 32'h80000104, 1, 0, 0);
        tick(); clr(); mret = 1;
        out("t2.cause", 1, 12'h342, 32'd2, 1, 0, 0);
        tick(); clr();
        out("t2.status", 1, 12'h300, 32'h1880, 1, 0, 0);
        tick();
        out("t2.redir", 0, 0, 0, 1, 1, 32'h80000000);
        tick();
        out("t2.done", 0, 0, 0, 0, 0, 0);
        exc = 1; cause = 32'h80000007; pc_exc = 32'h200; mtvec = 32'h80000001; mstatus = 32'h0;
        tick(); clr();
        out("t3.epc", 1, 12'h341, 32'h200, 1, 0, 0);
        tick(); out("t3.cause", 1, 12'h342, 32'h80000007, 1, 0, 0);
        tick(); out("t3.status", 1, 12'h300, 32'h1800, 1, 0, 0);
        tick(); out("t3.redir", 0, 0, 0, 1, 1, 32'h8000001C);
        tick();
        exc = 1; cause = 32'd5; pc_exc = 32'h300;
        tick(); clr();
        tick(); tick(); tick();
        out("t3b.sync_direct", 0, 0, 0, 1, 1, 32'h80000000);
        tick();
        sret = 1; pc_exc = 32'h303;
        tick(); clr();
        out("sret.epc", 1, 12'h341, 32'h300, 1, 0, 0);
        tick(); out("sret.cause", 1, 12'h342, 32'd2, 1, 0, 0);
        tick(); tick(); tick();
        mret = 1; mepc = 32'h80000108; mstatus = 32'h80;
        out("t4.idle", 0, 0, 0, 0, 0, 0);
        tick(); clr();
        out("t4.status", 1, 12'h300, 32'h1888, 1, 0, 0);
        tick(); out("t4.redir", 0, 0, 0, 1, 1, 32'h80000108);
        tick(); out("t4.done", 0, 0, 0, 0, 0, 0);
        exc = 1; we_c = 1; mret = 1; cause = 32'd3; pc_exc = 32'h400; addr_c = 12'h305;
        wdata_c = 32'h55; mtvec = 32'h100; mstatus = 32'h0;
        out("t5.idle", 0, 0, 0, 0, 0, 0);
        tick(); clr();
        out("t5.epc", 1, 12'h341, 32'h400, 1, 0, 0);
        tick(); out("t5.cause", 1, 12'h342, 32'd3, 1, 0, 0);
        tick(); tick(); out("t5.redir", 0, 0, 0, 1, 1, 32'h100);
        tick();
        exc = 1; cause = 32'd4; pc_exc = 32'h500;
        tick(); clr();
        tick();
        out("t6.cause", 1, 12'h342, 32'd4, 1, 0, 0);
        rst_n = 0;
        #1;
        chk("t6.we", {31'd0, csr_we}, 32'd0);
        chk("t6.wdata", csr_wdata, 32'd0);
        chk("t6.stall", {31'd0, stall}, 32'd0);
        @(negedge clk) rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            out("t6.after", 0, 0, 0, 0, 0, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
